// File: rtl/adc_rec_pkg.sv
// Shared types and default widths for the ADC record controller.
// The optional test-pattern source is enabled by defining ADC_TEST_PATTERN_EN.
package adc_rec_pkg;

    localparam int DEF_NUM_CH   = 8;
    localparam int DEF_SAMPLE_W = 12;
    localparam int DEF_ADDR_W   = 15;
    // The config record stores the record length at this width, so ADDR_W must not exceed it.
    localparam int MAX_ADDR_W   = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        DELAY   = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } rec_state_e;

    typedef struct packed {
        logic [15:0]           delay;
        logic [MAX_ADDR_W-1:0] len;
        logic [3:0]            decim;
        logic [7:0]            nrec;
    } rec_cfg_t;

endpackage

// File: rtl/adc_rec_sequencer.sv
// Capture sequencer: arm/trigger/delay/decimate state machine with word, record and address counters.
// frame_valid qualifies one frame per cycle and has no ready: every valid frame is either written or deliberately skipped.
module adc_rec_sequencer
    import adc_rec_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              ref_frame_clk,
    input  logic              state_reset_n,
    input  logic              arm_edge,
    input  logic              trig_edge,
    input  logic              abort,
    input  logic              frame_valid,
    input  logic [15:0]       trig_delay,
    input  logic [ADDR_W-1:0] rec_length,
    input  logic [3:0]        decim,
    input  logic [7:0]        num_records,
    output logic              accept,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        rec_count,
    output logic              trig_missed,
    output logic              overflow,
    output logic              data_ready,
    output rec_state_e        state
);

    rec_state_e        state_nxt;
    rec_cfg_t          cfg;
    logic [15:0]       delay_cnt;
    logic [3:0]        decim_cnt;
    logic [ADDR_W-1:0] word_cnt;
    logic              arm_take;
    logic              trig_take;
    logic              rec_end;
    logic              ovf_hit;
    logic              word_last;
    logic              last_rec;

    always_ff @(posedge ref_frame_clk or negedge state_reset_n) begin
        if (!state_reset_n) state <= IDLE;
        else                state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        arm_take  = 1'b0;
        trig_take = 1'b0;
        accept    = 1'b0;
        rec_end   = 1'b0;
        ovf_hit   = 1'b0;
        word_last = (MAX_ADDR_W'(word_cnt) == cfg.len);
        last_rec  = ((rec_count + 8'd1) >= cfg.nrec);
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (arm_edge) begin
                        arm_take  = 1'b1;
                        state_nxt = ARMED;
                    end
                end
                ARMED: begin
                    if (trig_edge) begin
                        trig_take = 1'b1;
                        state_nxt = (cfg.delay != 16'd0) ? DELAY : CAPTURE;
                    end
                end
                DELAY: begin
                    if (frame_valid && delay_cnt == 16'd1) state_nxt = CAPTURE;
                end
                CAPTURE: begin
                    if (frame_valid && decim_cnt == 4'd0) begin
                        accept = 1'b1;
                        // Top address with words still owed ends the sequence as an overflow.
                        if ((&addr) && !(word_last && last_rec)) begin
                            ovf_hit   = 1'b1;
                            state_nxt = DONE;
                        end else if (word_last) begin
                            rec_end   = 1'b1;
                            state_nxt = last_rec ? DONE : ARMED;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge ref_frame_clk or negedge state_reset_n) begin
        if (!state_reset_n) begin
            cfg         <= '0;
            delay_cnt   <= '0;
            decim_cnt   <= '0;
            word_cnt    <= '0;
            addr        <= '0;
            rec_count   <= '0;
            trig_missed <= 1'b0;
            overflow    <= 1'b0;
            data_ready  <= 1'b0;
        end else if (abort) begin
            data_ready <= 1'b0;
        end else begin
            if (arm_take) begin
                cfg.delay   <= trig_delay;
                cfg.len     <= MAX_ADDR_W'(rec_length);
                cfg.decim   <= decim;
                cfg.nrec    <= (num_records == 8'd0) ? 8'd1 : num_records;
                addr        <= '0;
                rec_count   <= '0;
                trig_missed <= 1'b0;
                overflow    <= 1'b0;
                data_ready  <= 1'b0;
            end
            if (trig_take) begin
                delay_cnt <= cfg.delay;
                decim_cnt <= '0;
                word_cnt  <= '0;
            end
            if (state == DELAY && frame_valid) delay_cnt <= delay_cnt - 16'd1;
            if (state == CAPTURE && frame_valid)
                decim_cnt <= (decim_cnt == cfg.decim) ? 4'd0 : decim_cnt + 4'd1;
            if (accept) begin
                addr     <= addr + 1'b1;
                word_cnt <= word_cnt + 1'b1;
            end
            if (rec_end) rec_count <= rec_count + 8'd1;
            if ((rec_end && last_rec) || ovf_hit) data_ready <= 1'b1;
            if (ovf_hit) overflow <= 1'b1;
            if (trig_edge && (state == DELAY || state == CAPTURE)) trig_missed <= 1'b1;
        end
    end

endmodule

// File: rtl/adc_record_ctrl.sv
// ADC record controller top: edge detection, word packing and registered RAM write port.
// Define ADC_TEST_PATTERN_EN to add iTestMode, which replaces samples with (addr + channel) ramps.
module adc_record_ctrl
    import adc_rec_pkg::*;
#(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = NUM_CH * SAMPLE_W,
    parameter int BE_W     = (DATA_W + 7) / 8
) (
    input  logic              ref_frame_clk,
    input  logic              iStateReset_n,
    input  logic [DATA_W-1:0] iFrameData,
    input  logic              iFrameValid,
`ifdef ADC_TEST_PATTERN_EN
    input  logic              iTestMode,
`endif
    input  logic              iArm,
    input  logic              iAbort,
    input  logic              iSystemTrig,
    input  logic [15:0]       iTrigDelay,
    input  logic [ADDR_W-1:0] iRecLength,
    input  logic [3:0]        iDecim,
    input  logic [7:0]        iNumRecords,
    output logic              oWREN,
    output logic [ADDR_W-1:0] oWAddr,
    output logic [DATA_W-1:0] oWData,
    output logic [BE_W-1:0]   oBYTEEN,
    output logic              oDataReady,
    output logic              oBusy,
    output logic [7:0]        oRecCount,
    output logic              oTrigMissed,
    output logic              oOverflow
);

    logic              arm_prev;
    logic              trig_prev;
    logic              arm_edge;
    logic              trig_edge;
    logic              accept;
    logic [ADDR_W-1:0] seq_addr;
    logic [DATA_W-1:0] wdata_nxt;
    rec_state_e        seq_state;

    assign arm_edge  = iArm & ~arm_prev;
    assign trig_edge = iSystemTrig & ~trig_prev;
    assign oBusy     = (seq_state == ARMED) || (seq_state == DELAY) || (seq_state == CAPTURE);

    always_ff @(posedge ref_frame_clk or negedge iStateReset_n) begin
        if (!iStateReset_n) begin
            arm_prev  <= 1'b0;
            trig_prev <= 1'b0;
        end else begin
            arm_prev  <= iArm;
            trig_prev <= iSystemTrig;
        end
    end

    adc_rec_sequencer #(
        .ADDR_W (ADDR_W)
    ) u_seq (
        .ref_frame_clk (ref_frame_clk),
        .state_reset_n (iStateReset_n),
        .arm_edge      (arm_edge),
        .trig_edge     (trig_edge),
        .abort         (iAbort),
        .frame_valid   (iFrameValid),
        .trig_delay    (iTrigDelay),
        .rec_length    (iRecLength),
        .decim         (iDecim),
        .num_records   (iNumRecords),
        .accept        (accept),
        .addr          (seq_addr),
        .rec_count     (oRecCount),
        .trig_missed   (oTrigMissed),
        .overflow      (oOverflow),
        .data_ready    (oDataReady),
        .state         (seq_state)
    );

`ifdef ADC_TEST_PATTERN_EN
    logic              test_mode;
    logic [DATA_W-1:0] pattern_word;

    // Latched on the same condition the sequencer uses to take an arm edge.
    always_ff @(posedge ref_frame_clk or negedge iStateReset_n) begin
        if (!iStateReset_n)                      test_mode <= 1'b0;
        else if (arm_edge && !iAbort && !oBusy) test_mode <= iTestMode;
    end

    always_comb begin
        pattern_word = '0;
        for (int k = 0; k < NUM_CH; k++)
            pattern_word[k*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(seq_addr) + SAMPLE_W'(k);
        wdata_nxt = test_mode ? pattern_word : iFrameData;
    end
`else
    assign wdata_nxt = iFrameData;
`endif

    always_ff @(posedge ref_frame_clk or negedge iStateReset_n) begin
        if (!iStateReset_n) begin
            oWREN   <= 1'b0;
            oWAddr  <= '0;
            oWData  <= '0;
            oBYTEEN <= '0;
        end else begin
            oWREN   <= accept;
            oBYTEEN <= accept ? '1 : '0;
            if (accept) begin
                oWAddr <= seq_addr;
                oWData <= wdata_nxt;
            end
        end
    end

endmodule

// File: tb/tb_adc_record_ctrl.sv
// Directed bench for adc_record_ctrl (ADDR_W=4): expected writes are queued as frames are issued,
// and a monitor pops and compares every RAM write.
module tb_adc_record_ctrl;

    localparam int NUM_CH   = 8;
    localparam int SAMPLE_W = 12;
    localparam int ADDR_W   = 4;
    localparam int DATA_W   = NUM_CH * SAMPLE_W;
    localparam int BE_W     = (DATA_W + 7) / 8;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] iFrameData;
    logic              iFrameValid;
    logic              iArm;
    logic              iAbort;
    logic              iSystemTrig;
    logic [15:0]       iTrigDelay;
    logic [ADDR_W-1:0] iRecLength;
    logic [3:0]        iDecim;
    logic [7:0]        iNumRecords;
    logic              oWREN;
    logic [ADDR_W-1:0] oWAddr;
    logic [DATA_W-1:0] oWData;
    logic [BE_W-1:0]   oBYTEEN;
    logic              oDataReady;
    logic              oBusy;
    logic [7:0]        oRecCount;
    logic              oTrigMissed;
    logic              oOverflow;

    int n_checks = 0;
    int n_fail   = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];

    adc_record_ctrl #(
        .NUM_CH   (NUM_CH),
        .SAMPLE_W (SAMPLE_W),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .BE_W     (BE_W)
    ) dut (
        .ref_frame_clk (clk),
        .iStateReset_n (rst_n),
        .iFrameData    (iFrameData),
        .iFrameValid   (iFrameValid),
`ifdef ADC_TEST_PATTERN_EN
        .iTestMode     (1'b0),
`endif
        .iArm          (iArm),
        .iAbort        (iAbort),
        .iSystemTrig   (iSystemTrig),
        .iTrigDelay    (iTrigDelay),
        .iRecLength    (iRecLength),
        .iDecim        (iDecim),
        .iNumRecords   (iNumRecords),
        .oWREN         (oWREN),
        .oWAddr        (oWAddr),
        .oWData        (oWData),
        .oBYTEEN       (oBYTEEN),
        .oDataReady    (oDataReady),
        .oBusy         (oBusy),
        .oRecCount     (oRecCount),
        .oTrigMissed   (oTrigMissed),
        .oOverflow     (oOverflow)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] mk_frame(input int f);
        logic [DATA_W-1:0] d;
        for (int k = 0; k < NUM_CH; k++) d[k*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(f * 16 + k);
        return d;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic expect_wr(input int a, input int f);
        exp_q.push_back({ADDR_W'(a), mk_frame(f)});
    endtask

    task automatic cyc(input bit v, input bit t, input int f);
        iFrameValid = v;
        iSystemTrig = t;
        iFrameData  = mk_frame(f);
        @(negedge clk);
    endtask

    task automatic arm(input int dly, input int len, input int dec, input int nrec, input bit trig);
        iTrigDelay  = 16'(dly);
        iRecLength  = ADDR_W'(len);
        iDecim      = 4'(dec);
        iNumRecords = 8'(nrec);
        iFrameValid = 1'b0;
        iSystemTrig = trig;
        iArm        = 1'b1;
        @(negedge clk);
        iArm = 1'b0;
    endtask

    task automatic drain(input string name);
        iFrameValid = 1'b0;
        iSystemTrig = 1'b0;
        repeat (3) @(negedge clk);
        check(name, 128'(exp_q.size()), 128'd0);
    endtask

    // Scoreboard monitor
    initial begin
        logic [ADDR_W+DATA_W-1:0] e;
        forever begin
            @(negedge clk);
            if (oWREN === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got write addr %0d data 0x%0h, expected no write", oWAddr, oWData);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 128'(oWAddr), 128'(e[DATA_W +: ADDR_W]));
                    check("wr_data", 128'(oWData), 128'(e[DATA_W-1:0]));
                    check("wr_byteen", 128'(oBYTEEN), {128{1'b1}} >> (128 - BE_W));
                end
            end else begin
                check("byteen_idle", 128'(oBYTEEN), 128'd0);
            end
        end
    end

    initial begin
        rst_n = 1'b0; iFrameData = '0; iFrameValid = 1'b0; iArm = 1'b0; iAbort = 1'b0;
        iSystemTrig = 1'b0; iTrigDelay = '0; iRecLength = '0; iDecim = '0; iNumRecords = '0;
        repeat (3) @(negedge clk);
        check("rst_wren", 128'(oWREN), 128'd0);
        check("rst_busy", 128'(oBusy), 128'd0);
        check("rst_ready", 128'(oDataReady), 128'd0);
        check("rst_reccount", 128'(oRecCount), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 128'(oBusy), 128'd0);

        // T1: arm+trig together only arms; single record of 4 words; config changes after arm ignored
        arm(0, 3, 0, 1, 1);
        iRecLength = '0; iDecim = 4'd5; iNumRecords = 8'd2;
        cyc(1, 1, 98);
        check("t1_armed_busy", 128'(oBusy), 128'd1);
        cyc(1, 0, 99);
        for (int i = 0; i < 4; i++) expect_wr(i, 101 + i);
        cyc(1, 1, 100);
        cyc(1, 1, 101);
        check("t1_latency_wren", 128'(oWREN), 128'd1);
        for (int f = 102; f <= 106; f++) cyc(1, 1, f);
        drain("t1_drain");
        check("t1_ready", 128'(oDataReady), 128'd1);
        check("t1_reccount", 128'(oRecCount), 128'd1);
        check("t1_busy", 128'(oBusy), 128'd0);

        // T2: decimate by 3, two words; re-arm from DONE
        arm(0, 1, 2, 1, 0);
        check("t2_rearm_ready", 128'(oDataReady), 128'd0);
        expect_wr(0, 201);
        expect_wr(1, 204);
        cyc(1, 1, 200);
        for (int f = 201; f <= 206; f++) cyc(1, 0, f);
        drain("t2_drain");
        check("t2_ready", 128'(oDataReady), 128'd1);

        // T3: trigger delay 5 with 50% valid; first write is the 6th valid frame
        arm(5, 1, 0, 1, 0);
        expect_wr(0, 306);
        expect_wr(1, 307);
        cyc(1, 1, 300);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0);
            cyc(1, 0, 301 + i);
        end
        drain("t3_drain");
        check("t3_ready", 128'(oDataReady), 128'd1);

        // T4: three records, extra trigger during capture
        arm(0, 1, 0, 3, 0);
        expect_wr(0, 401); expect_wr(1, 402); expect_wr(2, 404);
        expect_wr(3, 405); expect_wr(4, 407); expect_wr(5, 408);
        cyc(1, 1, 400);
        cyc(1, 0, 401);
        cyc(1, 1, 402);
        check("t4_rec1_count", 128'(oRecCount), 128'd1);
        check("t4_rec1_busy", 128'(oBusy), 128'd1);
        check("t4_missed_early", 128'(oTrigMissed), 128'd1);
        cyc(0, 0, 0);
        cyc(1, 1, 403); cyc(1, 0, 404); cyc(1, 0, 405);
        cyc(0, 0, 0);
        cyc(1, 1, 406); cyc(1, 0, 407); cyc(1, 0, 408);
        drain("t4_drain");
        check("t4_reccount", 128'(oRecCount), 128'd3);
        check("t4_missed", 128'(oTrigMissed), 128'd1);
        check("t4_ready", 128'(oDataReady), 128'd1);

        // T5: two records of 10 words overflow the 16-word space in record 2
        arm(0, 9, 0, 2, 0);
        check("t5_arm_clears_missed", 128'(oTrigMissed), 128'd0);
        for (int i = 0; i < 10; i++) expect_wr(i, 501 + i);
        for (int i = 0; i < 6; i++) expect_wr(10 + i, 512 + i);
        cyc(1, 1, 500);
        for (int f = 501; f <= 510; f++) cyc(1, 0, f);
        check("t5_rec1_count", 128'(oRecCount), 128'd1);
        cyc(0, 0, 0);
        cyc(1, 1, 511);
        for (int f = 512; f <= 519; f++) cyc(1, 0, f);
        drain("t5_drain");
        check("t5_overflow", 128'(oOverflow), 128'd1);
        check("t5_ready", 128'(oDataReady), 128'd1);
        check("t5_reccount", 128'(oRecCount), 128'd1);
        check("t5_busy", 128'(oBusy), 128'd0);

        // T6: abort after two writes
        arm(0, 7, 0, 1, 0);
        check("t6_arm_clears_ovf", 128'(oOverflow), 128'd0);
        check("t6_arm_clears_count", 128'(oRecCount), 128'd0);
        expect_wr(0, 601);
        expect_wr(1, 602);
        cyc(1, 1, 600);
        cyc(1, 0, 601);
        cyc(1, 0, 602);
        iAbort = 1'b1;
        cyc(1, 0, 603);
        iAbort = 1'b0;
        check("t6_abort_wren", 128'(oWREN), 128'd0);
        check("t6_abort_busy", 128'(oBusy), 128'd0);
        check("t6_abort_ready", 128'(oDataReady), 128'd0);
        for (int f = 604; f <= 607; f++) cyc(1, 0, f);
        drain("t6_drain");

        // T7: asynchronous reset while a write is on the port
        arm(0, 7, 0, 1, 0);
        expect_wr(0, 701);
        cyc(1, 1, 700);
        cyc(1, 0, 701);
        iFrameData = mk_frame(702);
        #2 rst_n = 1'b0;
        #1;
        check("t7_rst_wren", 128'(oWREN), 128'd0);
        check("t7_rst_wdata", 128'(oWData), 128'd0);
        check("t7_rst_byteen", 128'(oBYTEEN), 128'd0);
        check("t7_rst_busy", 128'(oBusy), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drain("t7_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
